// File: rtl/flag_update_arbiter.sv
// Purpose: sole writer of the status register; arbitrates ALU/sys flag writes and evaluates B.cond.
// Latency: grant is combinational, the write strobe follows one cycle later, and cond_taken is registered one cycle after accept.
// Backpressure: requests are held until granted; one write per 2+SETTLE_CYCLES cycles; branches stall while a write is pending or in flight.
module flag_update_arbiter #(
  parameter int ARB_MODE      = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_req,
  input  logic [3:0] alu_flags,
  output logic       alu_gnt,
  input  logic       sys_req,
  input  logic [3:0] sys_flags,
  output logic       sys_gnt,
  input  logic [3:0] sreg_flags,
  output logic       update_sreg,
  output logic [3:0] flags_out,
  input  logic       cond_req,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       cond_valid,
  output logic       cond_taken,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_settle_cnt;
  logic [3:0] w_settle_cnt_nxt;
  logic       r_rr_last;       // 1: sys was granted last, 0: ALU was
  logic [3:0] r_flags_out;
  logic       r_cond_valid;
  logic       r_cond_taken;
  logic       w_idle;
  logic       w_sys_wins;
  logic       w_cond_result;

  // Flags are {N,Z,C,V}; codes 14 and 15 both mean "always".
  function automatic logic f_cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'd0:    f_cond_eval = z;
      4'd1:    f_cond_eval = !z;
      4'd2:    f_cond_eval = c;
      4'd3:    f_cond_eval = !c;
      4'd4:    f_cond_eval = n;
      4'd5:    f_cond_eval = !n;
      4'd6:    f_cond_eval = v;
      4'd7:    f_cond_eval = !v;
      4'd8:    f_cond_eval = c & !z;
      4'd9:    f_cond_eval = !(c & !z);
      4'd10:   f_cond_eval = (n == v);
      4'd11:   f_cond_eval = (n != v);
      4'd12:   f_cond_eval = !z & (n == v);
      4'd13:   f_cond_eval = !(!z & (n == v));
      default: f_cond_eval = 1'b1;
    endcase
  endfunction

  assign update_sreg   = (r_state == S_ISSUE);
  assign busy          = (r_state != S_IDLE);
  assign flags_out     = r_flags_out;
  assign cond_valid    = r_cond_valid;
  assign cond_taken    = r_cond_taken;
  assign w_cond_result = f_cond_eval(cond_code, sreg_flags);

  // Arbitration, branch acceptance and next-state selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_idle           = (r_state == S_IDLE);
    // sys takes a tie in fixed-priority mode, or when ALU had the last grant
    w_sys_wins       = sys_req & (!alu_req | (ARB_MODE != 0) | !r_rr_last);
    alu_gnt          = w_idle & alu_req & !w_sys_wins;
    sys_gnt          = w_idle & sys_req & w_sys_wins;
    // any pending write beats the branch so it always sees the newest flags
    cond_ready       = cond_req & w_idle & !alu_req & !sys_req;
    case (r_state)
      S_IDLE: begin
        if (alu_gnt | sys_gnt) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt      = S_SETTLE;
        w_settle_cnt_nxt = 4'd0;
      end
      S_SETTLE: begin
        w_settle_cnt_nxt = r_settle_cnt + 4'd1;
        if (r_settle_cnt == LP_SETTLE_LAST) begin
          w_state_nxt      = S_IDLE;
          w_settle_cnt_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_settle_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State register, settle counter and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 4'd0;
      r_rr_last    <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      if (alu_gnt | sys_gnt) begin
        r_rr_last <= sys_gnt;
      end
    end
  end

  // Capture the winner's flags on the grant edge; they stay put until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags_out <= 4'd0;
    end else if (sys_gnt) begin
      r_flags_out <= sys_flags;
    end else if (alu_gnt) begin
      r_flags_out <= alu_flags;
    end
  end

  // Register the branch result on the accept edge; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cond_valid <= 1'b0;
      r_cond_taken <= 1'b0;
    end else begin
      r_cond_valid <= cond_ready;
      if (cond_ready) begin
        r_cond_taken <= w_cond_result;
      end
    end
  end

endmodule

// File: tb/tb_flag_update_arbiter.sv
// Three instances share stimulus: round-robin/settle 1, fixed-priority/settle 1, round-robin/settle 3.
module tb_flag_update_arbiter;

  localparam int N = 3;
  localparam int P_ARB [N] = '{0, 1, 0};
  localparam int P_SET [N] = '{1, 1, 3};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_req, sys_req, cond_req;
  logic [3:0] alu_flags, sys_flags, cond_code;
  logic [3:0] sreg_flags [N];

  logic       alu_gnt_w [N];
  logic       sys_gnt_w [N];
  logic       update_w [N];
  logic [3:0] flags_w [N];
  logic       cond_ready_w [N];
  logic       cond_valid_w [N];
  logic       cond_taken_w [N];
  logic       busy_w [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a countdown of cycles left in the write window.
  int         m_left [N];
  bit         m_last_sys [N];
  logic [3:0] m_flags [N];
  bit         m_cv [N];
  bit         m_ct [N];
  bit         pend_wr [N];
  bit         emu_sreg = 1'b0;

  // Logs used by the directed tests.
  int win_q0 [$];
  int win_q1 [$];
  int gnt_cyc2 [$];
  int first_ready0;
  int first_taken0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    flag_update_arbiter #(
      .ARB_MODE      ((g == 1) ? 1 : 0),
      .SETTLE_CYCLES ((g == 2) ? 3 : 1)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .alu_req     (alu_req),
      .alu_flags   (alu_flags),
      .alu_gnt     (alu_gnt_w[g]),
      .sys_req     (sys_req),
      .sys_flags   (sys_flags),
      .sys_gnt     (sys_gnt_w[g]),
      .sreg_flags  (sreg_flags[g]),
      .update_sreg (update_w[g]),
      .flags_out   (flags_w[g]),
      .cond_req    (cond_req),
      .cond_code   (cond_code),
      .cond_ready  (cond_ready_w[g]),
      .cond_valid  (cond_valid_w[g]),
      .cond_taken  (cond_taken_w[g]),
      .busy        (busy_w[g])
    );
  end

  // Codes come in complementary pairs; odd codes invert the base test, except 15 (always).
  function automatic bit cond_ref(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (code[0] && code != 4'd15) ? !base : base;
  endfunction

  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic exp_comb(input int k, output bit ag, output bit sg, output bit cr);
    bit idle;
    idle = (m_left[k] == 0);
    ag = 1'b0;
    sg = 1'b0;
    if (idle) begin
      if (alu_req && sys_req) begin
        sg = (P_ARB[k] == 1) || !m_last_sys[k];
        ag = !sg;
      end else begin
        ag = alu_req;
        sg = sys_req;
      end
    end
    cr = cond_req && idle && !alu_req && !sys_req;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_left[k] = 0; m_last_sys[k] = 1'b1; m_flags[k] = 4'd0;
      m_cv[k] = 1'b0; m_ct[k] = 1'b0; pend_wr[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    bit ag, sg, cr;
    for (int k = 0; k < N; k++) begin
      exp_comb(k, ag, sg, cr);
      chk("alu_gnt", k, 4'(alu_gnt_w[k]), 4'(ag));
      chk("sys_gnt", k, 4'(sys_gnt_w[k]), 4'(sg));
      chk("cond_ready", k, 4'(cond_ready_w[k]), 4'(cr));
      chk("update_sreg", k, 4'(update_w[k]), 4'(m_left[k] == 1 + P_SET[k]));
      chk("busy", k, 4'(busy_w[k]), 4'(m_left[k] > 0));
      chk("flags_out", k, flags_w[k], m_flags[k]);
      chk("cond_valid", k, 4'(cond_valid_w[k]), 4'(m_cv[k]));
      if (m_cv[k]) chk("cond_taken", k, 4'(cond_taken_w[k]), 4'(m_ct[k]));
    end
    if (alu_gnt_w[0]) win_q0.push_back(0);
    if (sys_gnt_w[0]) win_q0.push_back(1);
    if (alu_gnt_w[1]) win_q1.push_back(0);
    if (sys_gnt_w[1]) win_q1.push_back(1);
    if (alu_gnt_w[2] || sys_gnt_w[2]) gnt_cyc2.push_back(cyc);
    if (cond_ready_w[0] && first_ready0 < 0) first_ready0 = cyc;
    if (cond_valid_w[0] && first_taken0 < 0) first_taken0 = int'(cond_taken_w[0]);
  endtask

  task automatic model_update();
    bit ag, sg, cr;
    for (int k = 0; k < N; k++) begin
      exp_comb(k, ag, sg, cr);
      pend_wr[k] = (m_left[k] == 1 + P_SET[k]);
      m_cv[k] = cr;
      if (cr) m_ct[k] = cond_ref(cond_code, sreg_flags[k]);
      if (m_left[k] > 0) begin
        m_left[k]--;
      end else if (ag || sg) begin
        m_flags[k]    = sg ? sys_flags : alu_flags;
        m_left[k]     = 1 + P_SET[k];
        m_last_sys[k] = sg;
      end
    end
  endtask

  // One cycle: sample mid-cycle, clock, advance model, emulate status_register write-back.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    if (emu_sreg)
      for (int k = 0; k < N; k++)
        if (pend_wr[k]) sreg_flags[k] = m_flags[k];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    alu_req = 1'b0; sys_req = 1'b0; cond_req = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    alu_req = 1'b0; sys_req = 1'b0; cond_req = 1'b0;
    alu_flags = 4'd0; sys_flags = 4'd0; cond_code = 4'd0;
    for (int k = 0; k < N; k++) sreg_flags[k] = 4'd0;
    first_ready0 = -1; first_taken0 = -1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-ISSUE abandons the write at once; no strobe follows.
    alu_req = 1'b1; alu_flags = 4'b1010;
    step();
    alu_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    for (int k = 0; k < N; k++) begin
      chk("rst_update", k, 4'(update_w[k]), 4'd0);
      chk("rst_flags", k, flags_w[k], 4'd0);
      chk("rst_busy", k, 4'(busy_w[k]), 4'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step();

    // Single ALU write: grant now, strobe with 4'b0100 next cycle.
    alu_req = 1'b1; alu_flags = 4'b0100;
    step();
    alu_req = 1'b0;
    chk("t2_update", 0, 4'(update_w[0]), 4'd1);
    chk("t2_flags", 0, flags_w[0], 4'b0100);
    repeat (6) step();

    // Held conflicting requests: round-robin alternates from ALU, fixed priority favours sys.
    do_reset();
    win_q0.delete(); win_q1.delete();
    alu_req = 1'b1; sys_req = 1'b1; alu_flags = 4'b1000; sys_flags = 4'b0001;
    repeat (10) step();
    alu_req = 1'b0; sys_req = 1'b0;
    chk("t3_rr_count", 0, 4'(win_q0.size() >= 3), 4'd1);
    if (win_q0.size() >= 3) begin
      chk("t3_rr_first", 0, 4'(win_q0[0]), 4'd0);
      chk("t3_rr_second", 0, 4'(win_q0[1]), 4'd1);
      chk("t3_rr_third", 0, 4'(win_q0[2]), 4'd0);
    end
    chk("t3_fp_count", 1, 4'(win_q1.size() >= 2), 4'd1);
    if (win_q1.size() >= 2) begin
      chk("t3_fp_first", 1, 4'(win_q1[0]), 4'd1);
      chk("t3_fp_second", 1, 4'(win_q1[1]), 4'd1);
    end
    repeat (6) step();

    // Branch racing a write: stalls until idle and sees the freshly written Z.
    do_reset();
    emu_sreg = 1'b1;
    for (int k = 0; k < N; k++) sreg_flags[k] = 4'd0;
    first_ready0 = -1; first_taken0 = -1;
    alu_req = 1'b1; alu_flags = 4'b0100; cond_req = 1'b1; cond_code = 4'd0;
    step();
    alu_req = 1'b0;
    repeat (8) step();
    cond_req = 1'b0;
    chk("t4_ready_cycle", 0, 4'(first_ready0 - (cyc - 9)), 4'd3);
    chk("t4_taken", 0, 4'(first_taken0), 4'd1);
    emu_sreg = 1'b0;
    repeat (6) step();

    // Full condition table sweep while idle.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        for (int k = 0; k < N; k++) sreg_flags[k] = 4'(f);
        cond_code = 4'(c); cond_req = 1'b1;
        step();
      end
    end
    cond_req = 1'b0;
    step();

    // Sustained ALU requests with a 3-cycle settle: grants exactly 5 cycles apart.
    do_reset();
    gnt_cyc2.delete();
    alu_req = 1'b1; alu_flags = 4'b0011;
    repeat (18) step();
    alu_req = 1'b0;
    chk("t6_count", 2, 4'(gnt_cyc2.size() >= 4), 4'd1);
    for (int i = 1; i < gnt_cyc2.size() && i < 4; i++)
      chk("t6_spacing", 2, 4'(gnt_cyc2[i] - gnt_cyc2[i-1]), 4'd5);
    repeat (6) step();

    // Random traffic, with and without status_register write-back.
    for (int i = 0; i < 1500; i++) begin
      emu_sreg  = (i >= 750);
      alu_req   = ($urandom_range(0, 2) == 0);
      sys_req   = ($urandom_range(0, 2) == 0);
      cond_req  = ($urandom_range(0, 1) == 0);
      alu_flags = 4'($urandom);
      sys_flags = 4'($urandom);
      cond_code = 4'($urandom);
      if (!emu_sreg)
        for (int k = 0; k < N; k++) sreg_flags[k] = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
